mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
Load/store front-end placed directly upstream of the 32-bit byte-addressed data memory, which has word-only writes. It takes one RISC-V load/store request at a time from the core's MEM stage and issues memory reads. For loads it returns byte, half or word data with sign or zero extension. SB/SH are done as read-modify-write so that only the addressed bytes change; SW is a single write.

Parameters:
RD_LAT, 1, memory read latency in cycles: raddress is sampled at a clock edge and Dataout is valid RD_LAT cycles later (legal 1..4).
AW, 32, address width.

Ports:
Clk  input  1  clock
Reset_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  high only in IDLE
req_we  input  1  1 = store, 0 = load
req_funct3  input  3  RISC-V funct3 (LB 0, LH 1, LW 2, LBU 4, LHU 5; SB 0, SH 1, SW 2)
req_addr  input  AW  byte address
req_wdata  input  32  store data, right-aligned
resp_valid  output  1  one-cycle completion pulse
resp_rdata  output  32  extended load data; 0 for stores and errors
resp_err  output  1  illegal funct3 (or misaligned, see Optional Feature)
mem_raddress  output  AW  memory read address
mem_waddress  output  AW  memory write address
mem_datain  output  32  memory write data
mem_wr  output  1  memory write enable
mem_dataout  input  32  memory read data

Behaviour:
- Reset (async): state goes to IDLE. Outputs during and after reset: req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_wr=0, mem_datain=0, mem_waddress=0.
- A request is accepted in cycle T when req_valid && req_ready. On acceptance, addr, we, funct3 and wdata are registered.
- mem_raddress is req_addr while in IDLE and the registered addr in all other states, so the read is issued at the edge that ends cycle T.
- FSM states: IDLE, RD_WAIT, WRITE, RESP.
- IDLE→RESP: illegal funct3 (3, 6, 7 for loads; ≥3 for stores). resp_err=1; no memory write.
- IDLE→WRITE: SW.
- IDLE→RD_WAIT: loads, SB and SH.
- RD_WAIT: a down-counter holds the state for RD_LAT cycles. In the last of these cycles, mem_dataout is captured into rdata_q.
- RD_WAIT→RESP: loads. RD_WAIT→WRITE: SB/SH.
- WRITE: lasts one cycle. mem_wr=1 and mem_waddress=addr_q.
  - SW: mem_datain=wdata_q.
  - SH: mem_datain={rdata_q[31:16], wdata_q[15:0]}.
  - SB: mem_datain={rdata_q[31:8], wdata_q[7:0]}.
  - mem_wr is combinational from state, so it is never high outside WRITE.
- WRITE→RESP.
- RESP: lasts one cycle, then returns to IDLE.
  - resp_valid=1.
  - resp_rdata: LB = sign-extended rdata_q[7:0]; LBU = zero-extended [7:0]; LH/LHU = sign/zero-extended [15:0]; LW = rdata_q.
  - resp_rdata is registered: it holds its last value otherwise and reads 0 for stores.
- There is no response backpressure; the consumer must take resp_valid in that cycle.
- Latency from acceptance to resp_valid:
  - loads: RD_LAT+1 cycles
  - SW: 2 cycles
  - SB/SH: RD_LAT+2 cycles
  - error: 1 cycle
- req_valid outside IDLE is ignored; the requester holds it until req_ready.
- Unaligned addresses pass through unchanged, because the memory handles byte-lane addressing. Address arithmetic wraps mod 2^AW.
- Reset mid-operation: the transaction is abandoned and no partial write occurs. A reset during WRITE drops mem_wr asynchronously.

Optional Feature:
MEM_MISALIGN_TRAP_EN
- Defined: LH/LHU/SH with addr[0]≠0, or LW/SW with addr[1:0]≠0, go IDLE→RESP with resp_err=1. No read dependence and no write.
- Undefined: misaligned accesses execute normally and resp_err is set only for illegal funct3.

Decomposition:
- Package mem_access_pkg:
  - funct3 localparams F3_B, F3_H, F3_W, F3_BU, F3_HU
  - state enum typedef (IDLE, RD_WAIT, WRITE, RESP)
  - RD_LAT counter width constant
- Sub-module load_extend: combinational funct3 + 32-bit word → extended 32-bit result. Used in RESP; the bench verifies it on its own.

Test Plan:
- Memory word @0x10 = 0x80FF7F01, RD_LAT=1. Issue LB/LBU/LH/LHU/LW @0x10. Expected resp_rdata, each 2 cycles after acceptance: 0x00000001, 0x00000001, 0x00007F01, 0x00007F01, 0x80FF7F01. LB @0x12 → 0xFFFFFFFF and LBU @0x12 → 0x000000FF, via the byte-lane read.
- SW 0xDEADBEEF @0x20. Expect mem_wr high exactly one cycle, at T+1, with mem_waddress=0x20 and mem_datain=0xDEADBEEF; resp_valid at T+2 with resp_err=0.
- Memory @0x20 = 0xDEADBEEF. SB 0x123456AA @0x20 → write data 0xDEADBEAA. Then SH 0x0000CAFE @0x20 → 0xDEADCAFE. An LW afterwards returns 0xDEADCAFE. Repeat with RD_LAT=3: SB response arrives at T+5.
- Load with funct3=3 and store with funct3=4 → resp_valid at T+1 with resp_err=1 and resp_rdata=0; mem_wr stays 0 throughout.
- Assert Reset_n low during WRITE of an SB → mem_wr falls immediately and no resp_valid follows. After release, req_ready=1 and the next LW completes correctly.
- With MEM_MISALIGN_TRAP_EN: LW @0x22 → resp_err=1 at T+1. Without it: LW @0x22 returns memory bytes 0x22..0x25 with resp_err=0.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared constants and types for the load/store front-end (mem_access_unit).
package mem_access_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  // Wide enough to hold RD_LAT-1 for the legal read latencies 1..4.
  localparam int CNT_W = 3;

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    WRITE,
    RESP
  } state_e;

endpackage

// File: rtl/mem_access_unit_load_extend.sv
// Load result formatter: picks byte/half/word from the low lanes and sign- or zero-extends.
module load_extend
  import mem_access_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [31:0] word_i,
  output logic [31:0] result_o
);

  always_comb begin
    result_o = word_i;
    case (funct3_i)
      F3_B:    result_o = {{24{word_i[7]}}, word_i[7:0]};
      F3_BU:   result_o = {24'd0, word_i[7:0]};
      F3_H:    result_o = {{16{word_i[15]}}, word_i[15:0]};
      F3_HU:   result_o = {16'd0, word_i[15:0]};
      default: result_o = word_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// RISC-V load/store front-end for a word-write data memory; SB/SH done as read-modify-write.
// Build option MEM_MISALIGN_TRAP_EN: misaligned LH/LHU/SH/LW/SW respond with resp_err instead of executing.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int RD_LAT = 1,
  parameter int AW     = 32
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [2:0]    req_funct3,
  input  logic [AW-1:0] req_addr,
  input  logic [31:0]   req_wdata,
  output logic          resp_valid,
  output logic [31:0]   resp_rdata,
  output logic          resp_err,
  output logic [AW-1:0] mem_raddress,
  output logic [AW-1:0] mem_waddress,
  output logic [31:0]   mem_datain,
  output logic          mem_wr,
  input  logic [31:0]   mem_dataout
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:8]      rdata_q, rdata_d;
  logic [31:0]      resp_rdata_q, resp_rdata_d;
  logic [AW-1:0]    addr_q;
  logic             we_q;
  logic [2:0]       f3_q;
  logic [31:0]      wdata_q;
  logic             err_q;

  logic             accept;
  logic             illegal;
  logic             misalign;
  logic             req_err;
  logic [31:0]      ext_word;
  logic [31:0]      merged;

  assign accept = req_valid && (state_q == IDLE);

  always_comb begin
    illegal = 1'b0;
    if (req_we) begin
      illegal = (req_funct3 > F3_W);
    end else begin
      case (req_funct3)
        F3_B, F3_H, F3_W, F3_BU, F3_HU: illegal = 1'b0;
        default:                        illegal = 1'b1;
      endcase
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  always_comb begin
    misalign = 1'b0;
    case (req_funct3[1:0])
      2'd1:    misalign = req_addr[0];
      2'd2:    misalign = (req_addr[1:0] != 2'd0);
      default: misalign = 1'b0;
    endcase
  end
`else
  assign misalign = 1'b0;
`endif

  assign req_err = illegal || misalign;

  // Fed from the live read data so the registered response is ready on entry to RESP.
  load_extend u_load_extend (
    .funct3_i (f3_q),
    .word_i   (mem_dataout),
    .result_o (ext_word)
  );

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rdata_d      = rdata_q;
    resp_rdata_d = resp_rdata_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (req_err) begin
            state_d      = RESP;
            resp_rdata_d = '0;
          end else if (req_we && (req_funct3 == F3_W)) begin
            state_d = WRITE;
          end else begin
            state_d = RD_WAIT;
            cnt_d   = CNT_W'(RD_LAT - 1);
          end
        end
      end
      RD_WAIT: begin
        if (cnt_q == '0) begin
          rdata_d = mem_dataout[31:8];
          if (we_q) begin
            state_d = WRITE;
          end else begin
            state_d      = RESP;
            resp_rdata_d = ext_word;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      WRITE: begin
        state_d      = RESP;
        resp_rdata_d = '0;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      rdata_q      <= '0;
      resp_rdata_q <= '0;
      addr_q       <= '0;
      we_q         <= 1'b0;
      f3_q         <= 3'd0;
      wdata_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rdata_q      <= rdata_d;
      resp_rdata_q <= resp_rdata_d;
      if (accept) begin
        addr_q  <= req_addr;
        we_q    <= req_we;
        f3_q    <= req_funct3;
        wdata_q <= req_wdata;
        err_q   <= req_err;
      end
    end
  end

  always_comb begin
    merged = wdata_q;
    case (f3_q[1:0])
      2'd0:    merged = {rdata_q[31:8], wdata_q[7:0]};
      2'd1:    merged = {rdata_q[31:16], wdata_q[15:0]};
      default: merged = wdata_q;
    endcase
  end

  assign req_ready    = (state_q == IDLE);
  assign resp_valid   = (state_q == RESP);
  assign resp_err     = resp_valid && err_q;
  assign resp_rdata   = resp_rdata_q;
  assign mem_raddress = (state_q == IDLE) ? req_addr : addr_q;
  // Write strobe and write bus decode straight from state so reset kills them immediately.
  assign mem_wr       = (state_q == WRITE);
  assign mem_waddress = mem_wr ? addr_q : '0;
  assign mem_datain   = mem_wr ? merged : '0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: two instances (RD_LAT 1 and 3) against a byte-level memory model.
module tb_mem_access_unit;

  localparam int LAT0 = 1;
  localparam int LAT1 = 3;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  int          sel;

  logic        ready  [2];
  logic        rvalid [2];
  logic        rerr   [2];
  logic        wr     [2];
  logic [31:0] rdata  [2];
  logic [31:0] raddr  [2];
  logic [31:0] waddr  [2];
  logic [31:0] din    [2];
  logic [31:0] dout   [2];

  logic [2:0]  le_f3;
  logic [31:0] le_word;
  logic [31:0] le_res;

  int checks   = 0;
  int failures = 0;

  always #5 Clk = ~Clk;

  mem_access_unit #(.RD_LAT(LAT0), .AW(32)) u_dut0 (
    .Clk(Clk), .Reset_n(Reset_n),
    .req_valid(req_valid && (sel == 0)), .req_ready(ready[0]),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(rvalid[0]), .resp_rdata(rdata[0]), .resp_err(rerr[0]),
    .mem_raddress(raddr[0]), .mem_waddress(waddr[0]), .mem_datain(din[0]),
    .mem_wr(wr[0]), .mem_dataout(dout[0])
  );

  mem_access_unit #(.RD_LAT(LAT1), .AW(32)) u_dut1 (
    .Clk(Clk), .Reset_n(Reset_n),
    .req_valid(req_valid && (sel == 1)), .req_ready(ready[1]),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(rvalid[1]), .resp_rdata(rdata[1]), .resp_err(rerr[1]),
    .mem_raddress(raddr[1]), .mem_waddress(waddr[1]), .mem_datain(din[1]),
    .mem_wr(wr[1]), .mem_dataout(dout[1])
  );

  load_extend u_ext (
    .funct3_i (le_f3),
    .word_i   (le_word),
    .result_o (le_res)
  );

  // Initial memory image: word 0x80FF7F01 at 0x10, a simple pattern elsewhere.
  function automatic logic [7:0] init_byte(int i);
    case (i)
      16:      return 8'h01;
      17:      return 8'h7F;
      18:      return 8'hFF;
      19:      return 8'h80;
      default: return 8'(i * 29 + 7);
    endcase
  endfunction

  // Environment memory: byte-lane reads with RD_LAT pipeline, word-wide writes.
  logic [7:0]  env_mem [2][256];
  logic [31:0] pipe    [2][4];
  bit          seeded = 1'b0;

  always @(posedge Clk) begin : env
    logic [7:0] a;
    if (!seeded) begin
      for (int d = 0; d < 2; d++)
        for (int i = 0; i < 256; i++) env_mem[d][i] = init_byte(i);
      seeded = 1'b1;
    end
    for (int d = 0; d < 2; d++) begin
      a = raddr[d][7:0];
      pipe[d][0] <= {env_mem[d][8'(a + 8'd3)], env_mem[d][8'(a + 8'd2)],
                     env_mem[d][8'(a + 8'd1)], env_mem[d][a]};
      for (int k = 1; k < 4; k++) pipe[d][k] <= pipe[d][k-1];
      if (wr[d] === 1'b1)
        for (int j = 0; j < 4; j++) env_mem[d][8'(waddr[d][7:0] + 8'(j))] = din[d][8*j +: 8];
    end
  end

  assign dout[0] = pipe[0][LAT0-1];
  assign dout[1] = pipe[1][LAT1-1];

  // Reference memory, updated only by the model.
  logic [7:0] ref_mem [2][256];

  function automatic logic [31:0] ref_word(int d, logic [31:0] a);
    logic [31:0] w;
    for (int j = 0; j < 4; j++) w[8*j +: 8] = ref_mem[d][8'(a[7:0] + 8'(j))];
    return w;
  endfunction

  function automatic logic [31:0] ref_ext(logic [2:0] f3, logic [31:0] w);
    int     nb;
    longint v;
    nb = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    v  = longint'(w) % (64'sd1 <<< (8 * nb));
    if (!f3[2] && v >= (64'sd1 <<< (8 * nb - 1))) v = v - (64'sd1 <<< (8 * nb));
    return v[31:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic txn(input int d, input logic we, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] wd, output logic [31:0] got);
    int          nb, e_lat, wr_k, resp_k, nwr, lat;
    bit          illegal, mis, e_err, e_wr;
    logic [31:0] e_rd, e_din, w_a, w_d, r_d;
    logic        r_e;
    string       tag;
    lat     = (d == 0) ? LAT0 : LAT1;
    nb      = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    illegal = we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 > 3'd5);
    mis     = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
    mis = (int'(addr[1:0]) % nb) != 0;
`endif
    e_err = illegal || mis;
    e_rd  = '0;
    e_din = '0;
    e_wr  = 1'b0;
    if (e_err) begin
      e_lat = 1;
    end else if (!we) begin
      e_lat = lat + 1;
      e_rd  = ref_ext(f3, ref_word(d, addr));
    end else begin
      e_lat = (nb == 4) ? 2 : lat + 2;
      for (int j = 0; j < nb; j++) ref_mem[d][8'(addr[7:0] + 8'(j))] = wd[8*j +: 8];
      e_din = ref_word(d, addr);
      e_wr  = 1'b1;
    end
    tag = $sformatf("dut%0d we=%0d f3=%0d addr=%08h", d, we, f3, addr);

    @(negedge Clk);
    check({tag, " ready"}, 32'(ready[d]), 32'd1);
    sel        = d;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    req_valid  = 1'b1;
    @(posedge Clk);
    #1 req_valid = 1'b0;

    wr_k = 0; resp_k = 0; nwr = 0;
    w_a = '0; w_d = '0; r_d = '0; r_e = 1'b0;
    for (int k = 1; k <= 16 && resp_k == 0; k++) begin
      @(negedge Clk);
      if (wr[d] === 1'b1) begin
        nwr++;
        wr_k = k;
        w_a  = waddr[d];
        w_d  = din[d];
      end
      if (rvalid[d] === 1'b1) begin
        resp_k = k;
        r_d    = rdata[d];
        r_e    = rerr[d];
      end
    end
    check({tag, " resp_cycle"}, 32'(resp_k), 32'(e_lat));
    check({tag, " resp_err"}, 32'(r_e), 32'(e_err));
    check({tag, " resp_rdata"}, r_d, e_rd);
    check({tag, " write_count"}, 32'(nwr), 32'(e_wr));
    if (e_wr) begin
      check({tag, " write_cycle"}, 32'(wr_k), 32'(e_lat - 1));
      check({tag, " waddress"}, w_a, addr);
      check({tag, " datain"}, w_d, e_din);
    end
    got = r_d;
  endtask

  int legal_f3 [5] = '{0, 1, 2, 4, 5};

  initial begin
    logic [31:0] got;
    int          n_resp, n_wr;

    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 256; i++) ref_mem[d][i] = init_byte(i);
    Reset_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = '0; req_wdata = '0; sel = 0; le_f3 = 3'd0; le_word = '0;

    #3;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst%0d req_ready", d), 32'(ready[d]), 32'd1);
      check($sformatf("rst%0d resp_valid", d), 32'(rvalid[d]), 32'd0);
      check($sformatf("rst%0d resp_err", d), 32'(rerr[d]), 32'd0);
      check($sformatf("rst%0d resp_rdata", d), rdata[d], 32'd0);
      check($sformatf("rst%0d mem_wr", d), 32'(wr[d]), 32'd0);
      check($sformatf("rst%0d mem_datain", d), din[d], 32'd0);
      check($sformatf("rst%0d mem_waddress", d), waddr[d], 32'd0);
    end
    repeat (3) @(negedge Clk);
    Reset_n = 1'b1;

    // Loads of every width from 0x80FF7F01, then byte-lane reads at 0x12.
    txn(0, 1'b0, 3'd0, 32'h10, '0, got); check("plan LB@10", got, 32'h00000001);
    txn(0, 1'b0, 3'd4, 32'h10, '0, got); check("plan LBU@10", got, 32'h00000001);
    txn(0, 1'b0, 3'd1, 32'h10, '0, got); check("plan LH@10", got, 32'h00007F01);
    txn(0, 1'b0, 3'd5, 32'h10, '0, got); check("plan LHU@10", got, 32'h00007F01);
    txn(0, 1'b0, 3'd2, 32'h10, '0, got); check("plan LW@10", got, 32'h80FF7F01);
    txn(0, 1'b0, 3'd0, 32'h12, '0, got); check("plan LB@12", got, 32'hFFFFFFFF);
    txn(0, 1'b0, 3'd4, 32'h12, '0, got); check("plan LBU@12", got, 32'h000000FF);

    // SW / SB / SH read-modify-write on both latencies.
    for (int d = 0; d < 2; d++) begin
      txn(d, 1'b1, 3'd2, 32'h20, 32'hDEADBEEF, got);
      txn(d, 1'b1, 3'd0, 32'h20, 32'h123456AA, got);
      txn(d, 1'b0, 3'd2, 32'h20, '0, got); check($sformatf("plan dut%0d after SB", d), got, 32'hDEADBEAA);
      txn(d, 1'b1, 3'd1, 32'h20, 32'h0000CAFE, got);
      txn(d, 1'b0, 3'd2, 32'h20, '0, got); check($sformatf("plan dut%0d after SH", d), got, 32'hDEADCAFE);
      txn(d, 1'b0, 3'd3, 32'h20, '0, got);
      txn(d, 1'b1, 3'd4, 32'h24, 32'h55555555, got);
    end

    // Misaligned word load: trap or byte-lane read depending on build.
    txn(0, 1'b0, 3'd2, 32'h22, '0, got);
    txn(1, 1'b1, 3'd1, 32'h41, 32'h0000BEEF, got);

    // Reset asserted while an SB is in its WRITE cycle.
    @(negedge Clk);
    sel = 0; req_we = 1'b1; req_funct3 = 3'd0; req_addr = 32'h30;
    req_wdata = 32'h000000C3; req_valid = 1'b1;
    @(posedge Clk);
    #1 req_valid = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    check("rstmid mem_wr before", 32'(wr[0]), 32'd1);
    #1 Reset_n = 1'b0;
    #1;
    check("rstmid mem_wr async drop", 32'(wr[0]), 32'd0);
    n_resp = 0; n_wr = 0;
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    repeat (4) begin
      @(negedge Clk);
      if (rvalid[0] !== 1'b0) n_resp++;
      if (wr[0] !== 1'b0) n_wr++;
    end
    check("rstmid resp after reset", 32'(n_resp), 32'd0);
    check("rstmid write after reset", 32'(n_wr), 32'd0);
    check("rstmid req_ready", 32'(ready[0]), 32'd1);
    txn(0, 1'b0, 3'd2, 32'h30, '0, got);

    // Extender on its own.
    for (int i = 0; i < 20; i++) begin
      le_f3   = 3'(legal_f3[$urandom_range(0, 4)]);
      le_word = (i == 0) ? 32'h00000080 : (i == 1) ? 32'h00008000 : $urandom();
      #1;
      check($sformatf("load_extend f3=%0d word=%08h", le_f3, le_word), le_res, ref_ext(le_f3, le_word));
    end

    // Randomised mix of loads, stores and illegal encodings.
    for (int i = 0; i < 80; i++) begin
      txn($urandom_range(0, 1), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
          $urandom(), $urandom(), got);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
